// File: rtl/pixel_burst_writer_pkg.sv
// Shared types and constants for the pixel burst writer: FSM states, AXI response
// codes and the 4 KB burst boundary used to split runs.
package pixel_burst_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        CALC2,
        ADDR,
        DATA,
        RESP,
        DONE
    } pbw_state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [31:0] BOUNDARY_4K = 32'h0000_1000;

    // Whole 32-bit pixels left before the next 4 KB page starts.
    function automatic logic [31:0] pixelsToBoundary(input logic [31:0] addr);
        return (BOUNDARY_4K - {20'd0, addr[11:0]}) >> 2;
    endfunction

endpackage

// File: rtl/pixel_burst_writer_addr_calc.sv
// Address and segment calculation for one pixel run: byte address, beat count and,
// when the run crosses a 4 KB page, the second segment that starts on the new page.
module pbw_addr_calc
    import pixel_burst_writer_pkg::*;
(
    input  logic signed [31:0] start_i,
    input  logic signed [31:0] end_i,
    input  logic signed [31:0] row_i,
    input  logic        [31:0] fb_base_i,
    output logic        [31:0] addr0_o,
    output logic        [8:0]  beats0_o,
    output logic               split_o,
    output logic        [31:0] addr1_o,
    output logic        [8:0]  beats1_o
);

    logic [31:0] pixOffset;
    logic [31:0] beatsAll;
    logic [31:0] pixToBoundary;

    // A run is at most BURST_LEN pixels, far below one page, so two segments suffice.
    always_comb begin
        pixOffset     = 32'(row_i + start_i);
        addr0_o       = fb_base_i + (pixOffset << 2);
        beatsAll      = 32'(end_i - start_i + 32'sd1);
        pixToBoundary = pixelsToBoundary(addr0_o);
        split_o       = beatsAll > pixToBoundary;
        addr1_o       = {addr0_o[31:12] + 20'd1, 12'd0};
        if (split_o) begin
            beats0_o = pixToBoundary[8:0];
            beats1_o = beatsAll[8:0] - pixToBoundary[8:0];
        end else begin
            beats0_o = beatsAll[8:0];
            beats1_o = 9'd0;
        end
    end

endmodule

// File: rtl/pixel_burst_writer.sv
// Pixel burst writer: fills one horizontal pixel run with a colour over AXI4 writes,
// splitting at 4 KB pages. Define CLIP_EN to clip runs to the visible screen first.
module pixel_burst_writer
    import pixel_burst_writer_pkg::*;
#(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BURST_LEN = 128
) (
    input  logic               clk100,
    input  logic               reset,
    input  logic               txn_init,
    output logic               txn_done,
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    input  logic signed [31:0] pixel_count,
    input  logic        [31:0] color,
    input  logic        [31:0] fb_base,
    output logic        [31:0] m_axi_awaddr,
    output logic        [7:0]  m_axi_awlen,
    output logic               m_axi_awvalid,
    input  logic               m_axi_awready,
    output logic        [31:0] m_axi_wdata,
    output logic        [3:0]  m_axi_wstrb,
    output logic               m_axi_wlast,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,
    input  logic        [1:0]  m_axi_bresp,
    input  logic               m_axi_bvalid,
    output logic               m_axi_bready,
    output logic               wr_error
);

    localparam logic signed [31:0] SCREEN_W_S  = 32'(SCREEN_W);
    localparam logic signed [31:0] BURST_LEN_S = 32'(BURST_LEN);
`ifdef CLIP_EN
    localparam logic signed [31:0] SCREEN_H_S  = 32'(SCREEN_H);
`endif

    pbw_state_e         state_q, state_d;
    logic               txnInit_q, txnInit_d;
    logic signed [31:0] x_q, x_d, y_q, y_d, count_q, count_d;
    logic        [31:0] color_q, color_d;
    logic signed [31:0] start_q, start_d, end_q, end_d, row_q, row_d;
    logic               empty_q, empty_d;
    logic        [31:0] curAddr_q, curAddr_d, nextAddr_q, nextAddr_d;
    logic        [8:0]  curBeats_q, curBeats_d, nextBeats_q, nextBeats_d;
    logic        [8:0]  beatCnt_q, beatCnt_d;
    logic               split_q, split_d;
    logic               wrError_q, wrError_d;

    logic signed [31:0] rawEnd;
    logic               countBad;
    logic               lastBeat;
    logic        [31:0] calcAddr0, calcAddr1;
    logic        [8:0]  calcBeats0, calcBeats1;
    logic               calcSplit;

    pbw_addr_calc u_addr_calc (
        .start_i   (start_q),
        .end_i     (end_q),
        .row_i     (row_q),
        .fb_base_i (fb_base),
        .addr0_o   (calcAddr0),
        .beats0_o  (calcBeats0),
        .split_o   (calcSplit),
        .addr1_o   (calcAddr1),
        .beats1_o  (calcBeats1)
    );

    // The txn_init copy resets high so a request already raised during reset is not taken.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q     <= IDLE;
            txnInit_q   <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            count_q     <= '0;
            color_q     <= '0;
            start_q     <= '0;
            end_q       <= '0;
            row_q       <= '0;
            empty_q     <= 1'b0;
            curAddr_q   <= '0;
            curBeats_q  <= '0;
            nextAddr_q  <= '0;
            nextBeats_q <= '0;
            beatCnt_q   <= '0;
            split_q     <= 1'b0;
            wrError_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            txnInit_q   <= txnInit_d;
            x_q         <= x_d;
            y_q         <= y_d;
            count_q     <= count_d;
            color_q     <= color_d;
            start_q     <= start_d;
            end_q       <= end_d;
            row_q       <= row_d;
            empty_q     <= empty_d;
            curAddr_q   <= curAddr_d;
            curBeats_q  <= curBeats_d;
            nextAddr_q  <= nextAddr_d;
            nextBeats_q <= nextBeats_d;
            beatCnt_q   <= beatCnt_d;
            split_q     <= split_d;
            wrError_q   <= wrError_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        txnInit_d   = txn_init;
        x_d         = x_q;
        y_d         = y_q;
        count_d     = count_q;
        color_d     = color_q;
        start_d     = start_q;
        end_d       = end_q;
        row_d       = row_q;
        empty_d     = empty_q;
        curAddr_d   = curAddr_q;
        curBeats_d  = curBeats_q;
        nextAddr_d  = nextAddr_q;
        nextBeats_d = nextBeats_q;
        beatCnt_d   = beatCnt_q;
        split_d     = split_q;
        wrError_d   = wrError_q;

        rawEnd   = x_q + count_q - 32'sd1;
        countBad = (count_q <= 32'sd0) || (count_q > BURST_LEN_S);
        lastBeat = (beatCnt_q == curBeats_q - 9'd1);

        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        txn_done      = 1'b0;
        wr_error      = wrError_q;

        unique case (state_q)
            IDLE: begin
                if (txn_init && !txnInit_q) begin
                    x_d     = x;
                    y_d     = y;
                    count_d = pixel_count;
                    color_d = color;
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef CLIP_EN
                start_d = (x_q < 32'sd0) ? 32'sd0 : x_q;
                end_d   = (rawEnd > SCREEN_W_S - 32'sd1) ? SCREEN_W_S - 32'sd1 : rawEnd;
                empty_d = countBad || (start_d > end_d) ||
                          (y_q < 32'sd0) || (y_q >= SCREEN_H_S);
`else
                start_d = x_q;
                end_d   = rawEnd;
                empty_d = countBad;
`endif
                row_d   = y_q * SCREEN_W_S;
                state_d = CALC2;
            end
            CALC2: begin
                if (empty_q) begin
                    state_d = DONE;
                end else begin
                    curAddr_d   = calcAddr0;
                    curBeats_d  = calcBeats0;
                    split_d     = calcSplit;
                    nextAddr_d  = calcAddr1;
                    nextBeats_d = calcBeats1;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                m_axi_awvalid = 1'b1;
                m_axi_awaddr  = curAddr_q;
                m_axi_awlen   = 8'(curBeats_q - 9'd1);
                if (m_axi_awready) begin
                    beatCnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                m_axi_wvalid = 1'b1;
                m_axi_wdata  = color_q;
                m_axi_wstrb  = 4'hF;
                m_axi_wlast  = lastBeat;
                if (m_axi_wready) begin
                    if (lastBeat) begin
                        state_d = RESP;
                    end else begin
                        beatCnt_d = beatCnt_q + 9'd1;
                    end
                end
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != RESP_OKAY) begin
                        wrError_d = 1'b1;
                    end
                    // The page-crossing remainder goes out only after the first segment is acknowledged.
                    if (split_q) begin
                        curAddr_d  = nextAddr_q;
                        curBeats_d = nextBeats_q;
                        split_d    = 1'b0;
                        state_d    = ADDR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                txn_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
